// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Purpose : bundles the field-tuple input handshake, the instruction-memory
//           output handshake, the address-load control and the occupancy
//           status of the instruction encoder.
// Signals :
//   in_valid / in_ready        tuple handshake (loader -> encoder)
//   opcode, imm_present, funct,
//   dest_reg, src_reg, imm     instruction fields of the tuple
//   out_valid / out_ready      word handshake (encoder -> instruction memory)
//   out_instr, out_addr        encoded word and its write address
//   addr_load, addr_base       load a new base write address
//   count                      FIFO occupancy
// Modports:
//   master : loader / memory side (drives tuples, out_ready, address load)
//   slave  : encoder side
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 opcode;
    logic                       imm_present;
    logic [2:0]                 funct;
    logic [3:0]                 dest_reg;
    logic [3:0]                 src_reg;
    logic [15:0]                imm;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                out_instr;
    logic [ADDR_W-1:0]          out_addr;
    logic                       addr_load;
    logic [ADDR_W-1:0]          addr_base;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output in_valid, opcode, imm_present, funct, dest_reg, src_reg, imm,
        output out_ready, addr_load, addr_base,
        input  in_ready, out_valid, out_instr, out_addr, count
    );

    modport slave (
        input  in_valid, opcode, imm_present, funct, dest_reg, src_reg, imm,
        input  out_ready, addr_load, addr_base,
        output in_ready, out_valid, out_instr, out_addr, count
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Purpose : packs instruction field tuples into 32-bit instruction words,
//           buffers them in a DEPTH-entry FIFO and streams them to
//           instruction memory with an auto-incrementing write address.
// Ports   :
//   clk    clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    instr_encoder_if.slave (tuple input, word output, address load,
//          occupancy)
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0] word;
    logic        in_ready_w;
    logic        out_valid_w;
    logic        push;
    logic        pop;

    // Immediate field is zeroed when the instruction carries no immediate.
    assign word = {bus.opcode, bus.imm_present, bus.funct, bus.dest_reg,
                   bus.src_reg, bus.imm_present ? bus.imm : 16'h0000};

    // Ready depends on occupancy only, so a full FIFO never admits a push
    // even if a pop happens in the same cycle.
    assign in_ready_w  = (count_q != FULL);
    assign out_valid_w = (count_q != '0);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A load wins over the pop increment; the popped word already used
        // the old address.
        if (bus.addr_load) begin
            addr_d = bus.addr_base;
        end else if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_instr = out_valid_w ? mem_q[rd_ptr_q] : 32'h0;
    assign bus.out_addr  = addr_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic clk;
    logic reset;

    instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of pending words plus the next write address.
    logic [31:0]       model_q [$];
    logic [ADDR_W-1:0] model_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [3:0] op, input logic ip,
                                               input logic [2:0] fn, input logic [3:0] rd,
                                               input logic [3:0] rs, input logic [15:0] im);
        logic [31:0] w;
        w = (32'(op) << 28) + (32'(ip) << 27) + (32'(fn) << 24)
          + (32'(rd) << 20) + (32'(rs) << 16);
        if (ip) w = w + 32'(im);
        return w;
    endfunction

    task automatic check_model();
        int n;
        n = model_q.size();
        chk("count",     32'(bus.count),     32'(n));
        chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
        chk("in_ready",  32'(bus.in_ready),  32'(n != DEPTH));
        chk("out_instr", bus.out_instr,      (n != 0) ? model_q[0] : 32'h0);
        chk("out_addr",  32'(bus.out_addr),  32'(model_addr));
    endtask

    // Apply one cycle of inputs, clock it, advance the model, then check.
    task automatic step(input logic v, input logic [3:0] op, input logic ip,
                        input logic [2:0] fn, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] im, input logic ordy, input logic ld,
                        input logic [ADDR_W-1:0] base, input logic rst);
        bit push_m, pop_m;
        reset           = rst;
        bus.in_valid    = v;
        bus.opcode      = op;
        bus.imm_present = ip;
        bus.funct       = fn;
        bus.dest_reg    = rd;
        bus.src_reg     = rs;
        bus.imm         = im;
        bus.out_ready   = ordy;
        bus.addr_load   = ld;
        bus.addr_base   = base;
        push_m = v && (model_q.size() != DEPTH);
        pop_m  = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_addr = '0;
        end else begin
            if (pop_m) void'(model_q.pop_front());
            if (ld) model_addr = base;
            else if (pop_m) model_addr = model_addr + 1'b1;
            if (push_m) model_q.push_back(model_word(op, ip, fn, rd, rs, im));
        end
        #1;
        check_model();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'h0, 1'b0, 3'h0, 4'h0, 4'h0, 16'h0, ordy, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 4'h0, 1'b0, 3'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic push_imm(input logic [15:0] im, input logic ordy);
        step(1'b1, 4'h5, 1'b1, 3'h3, 4'h1, 4'h2, im, ordy, 1'b0, '0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.opcode = '0; bus.imm_present = 1'b0; bus.funct = '0;
        bus.dest_reg = '0; bus.src_reg = '0; bus.imm = '0; bus.out_ready = 1'b0;
        bus.addr_load = 1'b0; bus.addr_base = '0;

        do_reset();
        do_reset();
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_instr",  bus.out_instr, 32'h0);

        // Encode with immediate
        step(1'b1, 4'hA, 1'b1, 3'b101, 4'd3, 4'd7, 16'hBEEF, 1'b1, 1'b0, '0, 1'b0);
        chk("enc_imm", bus.out_instr, 32'hAD37BEEF);
        chk("enc_imm_addr", 32'(bus.out_addr), 32'h0);
        idle(1'b1);
        chk("enc_imm_drained", 32'(bus.count), 32'd0);

        // Encode without immediate
        step(1'b1, 4'h2, 1'b0, 3'b000, 4'd1, 4'd2, 16'h1234, 1'b0, 1'b0, '0, 1'b0);
        chk("enc_noimm", bus.out_instr, 32'h20120000);
        idle(1'b1);

        // Fill then drain
        do_reset();
        for (int k = 1; k <= 6; k++) push_imm(16'(k), 1'b0);
        chk("fill_ready", 32'(bus.in_ready), 32'd0);
        chk("fill_count", 32'(bus.count), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_imm",  32'(bus.out_instr[15:0]), 32'(k));
            chk("drain_addr", 32'(bus.out_addr), 32'(k - 1));
            idle(1'b1);
        end
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Full FIFO: simultaneous pop does not admit a push
        for (int k = 1; k <= 4; k++) push_imm(16'(k + 16), 1'b0);
        push_imm(16'h0099, 1'b1);
        chk("full_no_push", 32'(bus.count), 32'd3);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Streaming
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_imm(16'(i), 1'b1);
            chk("stream_count", 32'(bus.count), 32'd1);
            chk("stream_addr",  32'(bus.out_addr), 32'(i));
        end
        idle(1'b1);

        // Address wrap and load-over-pop
        for (int k = 0; k < 3; k++) push_imm(16'(k), 1'b0);
        step(1'b1, 4'h1, 1'b1, 3'h0, 4'h0, 4'h0, 16'h0003, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        chk("wrap_a0", 32'(bus.out_addr), 32'hFFFE);
        idle(1'b1);
        chk("wrap_a1", 32'(bus.out_addr), 32'hFFFF);
        idle(1'b1);
        chk("wrap_a2", 32'(bus.out_addr), 32'h0000);
        idle(1'b1);
        chk("wrap_a3", 32'(bus.out_addr), 32'h0001);
        push_imm(16'h0042, 1'b0);
        step(1'b0, 4'h0, 1'b0, 3'h0, 4'h0, 4'h0, 16'h0, 1'b1, 1'b1, 16'h0005, 1'b0);
        chk("load_over_pop", 32'(bus.out_addr), 32'h0005);
        chk("load_keeps_fifo", 32'(bus.count), 32'd1);
        idle(1'b1);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) push_imm(16'(k + 7), 1'b0);
        step(1'b1, 4'hF, 1'b1, 3'h7, 4'hF, 4'hF, 16'hFFFF, 1'b1, 1'b0, '0, 1'b1);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_addr",  32'(bus.out_addr), 32'd0);
        idle(1'b0);
        chk("midrst_not_stored", 32'(bus.count), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom), 3'($urandom),
                 4'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                 ADDR_W'($urandom), 1'($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
